// File: rtl/rf_pkg.sv
// Shared types for the regfile writeback arbiter.
// Width macros WORD / REG_SIZE / REG_COUNT fall back to RV32 values.
`ifndef WORD
`define WORD 32
`endif
`ifndef REG_SIZE
`define REG_SIZE 5
`endif
`ifndef REG_COUNT
`define REG_COUNT 32
`endif

package rf_pkg;

  localparam int WORD_W = `WORD;
  localparam int REG_W  = `REG_SIZE;
  localparam int REG_N  = `REG_COUNT;

  typedef logic [REG_W-1:0]  reg_addr_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_req_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set on reserve, cleared on writeback.
// A set and clear of the same register on one edge leaves it set.
`ifndef REG_SIZE
`define REG_SIZE 5
`endif
`ifndef REG_COUNT
`define REG_COUNT 32
`endif

module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int REG_SIZE  = `REG_SIZE,
  parameter int REG_COUNT = `REG_COUNT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [REG_SIZE-1:0] set_addr,
  input  logic                clr_en,
  input  logic [REG_SIZE-1:0] clr_addr,
  input  logic [REG_SIZE-1:0] q_addr1,
  input  logic [REG_SIZE-1:0] q_addr2,
  output logic                q_busy1,
  output logic                q_busy2
);

  logic [REG_COUNT-1:0] pending;
  logic [REG_COUNT-1:0] pend_nxt;

  always_comb begin
    pend_nxt = pending;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (clr_en && clr_addr == REG_SIZE'(i))
        pend_nxt[i] = 1'b0;
      if (set_en && set_addr == REG_SIZE'(i))
        pend_nxt[i] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pend_nxt;
  end

  assign q_busy1 = pending[q_addr1];
  assign q_busy2 = pending[q_addr2];

  a_rsv_free: assert property (
    @(posedge clk) disable iff (!rst_n)
    set_en |-> (!pending[set_addr] ||
                (clr_en && clr_addr == set_addr)));

  a_clr_pend: assert property (
    @(posedge clk) disable iff (!rst_n)
    clr_en |-> pending[clr_addr]);

endmodule

// File: rtl/rf_wport_arbiter.sv
// Round-robin share of the regfile write port between ALU and LSU.
// Define RF_WB_FWD_EN to expose write-cycle forwarding outputs.
`ifndef WORD
`define WORD 32
`endif
`ifndef REG_SIZE
`define REG_SIZE 5
`endif
`ifndef REG_COUNT
`define REG_COUNT 32
`endif

module rf_wport_arbiter
  import rf_pkg::*;
#(
  parameter int WORD      = `WORD,
  parameter int REG_SIZE  = `REG_SIZE,
  parameter int REG_COUNT = `REG_COUNT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [REG_SIZE-1:0] req_addr0,
  input  logic [REG_SIZE-1:0] req_addr1,
  input  logic [WORD-1:0]     req_data0,
  input  logic [WORD-1:0]     req_data1,
  input  logic                rsv_valid,
  input  logic [REG_SIZE-1:0] rsv_addr,
  input  logic [REG_SIZE-1:0] q_addr1,
  input  logic [REG_SIZE-1:0] q_addr2,
  output logic                q_busy1,
  output logic                q_busy2,
  output logic                wr_en,
  output logic [REG_SIZE-1:0] wr_addr,
  output logic [WORD-1:0]     wr_data
`ifdef RF_WB_FWD_EN
  ,
  output logic                fwd_hit1,
  output logic                fwd_hit2,
  output logic [WORD-1:0]     fwd_data
`endif
);

  wb_req_e             rr;
  wb_req_e             win;
  logic                hs;
  logic [REG_SIZE-1:0] win_addr;
  logic [WORD-1:0]     win_data;

  always_comb begin
    req_ready = 2'b00;
    if (rst_n) begin
      if (req_valid == 2'b11)
        req_ready = (rr == WB_LSU) ? 2'b10 : 2'b01;
      else
        req_ready = req_valid;
    end
  end

  assign hs       = |(req_valid & req_ready);
  assign win      = req_ready[1] ? WB_LSU : WB_ALU;
  assign win_addr = (win == WB_LSU) ? req_addr1 : req_addr0;
  assign win_data = (win == WB_LSU) ? req_data1 : req_data0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr      <= WB_ALU;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= hs && (win_addr != '0);
      if (hs) begin
        rr      <= (win == WB_ALU) ? WB_LSU : WB_ALU;
        wr_addr <= win_addr;
        wr_data <= win_data;
      end
    end
  end

  rf_scoreboard #(
    .REG_SIZE  (REG_SIZE),
    .REG_COUNT (REG_COUNT)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (rsv_valid && (rsv_addr != '0)),
    .set_addr (rsv_addr),
    .clr_en   (hs && (win_addr != '0)),
    .clr_addr (win_addr),
    .q_addr1  (q_addr1),
    .q_addr2  (q_addr2),
    .q_busy1  (q_busy1),
    .q_busy2  (q_busy2)
  );

`ifdef RF_WB_FWD_EN
  assign fwd_hit1 = wr_en && (wr_addr == q_addr1) && (q_addr1 != '0);
  assign fwd_hit2 = wr_en && (wr_addr == q_addr2) && (q_addr2 != '0);
  assign fwd_data = wr_data;
`endif

  a_same_dst: assert property (
    @(posedge clk) disable iff (!rst_n)
    (req_valid == 2'b11 && req_addr0 != '0)
      |-> (req_addr0 != req_addr1));

endmodule
